spi_master: RTL and testbench

//  SPI master (mode 0: CPOL=0, CPHA=0, MSB first) driving the existing SPI slave from the FPGA fabric.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_clk_div.sv | 33 +++
 rtl/spi_master.sv | 166 ++++++++++++++++
 tb/tb_spi_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slice.
// Contents: spi_state_t (transfer FSM states), SPI_W (bits per transfer),
//           DIV_W (width of the phase divider counter), is_ready_state().
package spi_pkg;

   localparam int unsigned SPI_W = 8;
   localparam int unsigned DIV_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      TRAIL,
      BWAIT,
      GAP
   } spi_state_t;

   // States in which a new start request is accepted.
   function automatic logic is_ready_state(input spi_state_t s);
      return (s == IDLE) || (s == BWAIT);
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Phase timer for the SPI master: every FSM phase lasts CLK_DIV clk cycles.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-low reset
//   load    in   reload to CLK_DIV-1 (asserted on every phase entry)
//   tick_c  out  combinational, high in the last cycle of the current phase
module spi_clk_div
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic tick_c
);

   logic [DIV_W-1:0] cnt;

   // Down-counter; parks at zero when no phase is running.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= DIV_W'(CLK_DIV - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - DIV_W'(1);
      end
   end

   assign tick_c = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, with multi-byte bursts.
// Build option: define SPI_LOOPBACK_EN to sample the registered mosi instead
// of the miso pin (pin-level outputs are identical in both builds).
// Ports:
//   clk, reset          system clock, synchronous active-low reset
//   start, burst        transfer request; burst=1 keeps slave_sel low afterwards
//   tx_data             byte to send, latched on accepted start
//   busy, ready         transfer/select active; start accepted this cycle
//   done, rx_data       1-cycle pulse with the received byte (held until next done)
//   s_clk, mosi, miso   SPI serial clock and data
//   slave_sel           active-low chip select
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned DATA_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             burst,
   input  logic [SPI_W-1:0] tx_data,
   output logic             busy,
   output logic             ready,
   output logic             done,
   output logic [SPI_W-1:0] rx_data,
   output logic             s_clk,
   output logic             mosi,
   input  logic             miso,
   output logic             slave_sel
);

   // Elaboration-time parameter checks.
   if ((CLK_DIV < 2) || (CLK_DIV > 255)) begin : g_bad_clk_div
      $error("spi_master: CLK_DIV must be within 2..255");
   end
   if (DATA_W != SPI_W) begin : g_bad_data_w
      $error("spi_master: DATA_W must be 8");
   end

   spi_state_t       state;
   logic [SPI_W-2:0] tx_shift;   // remaining bits after the MSB already on mosi
   logic [SPI_W-1:0] rx_shift;
   logic [2:0]       bit_cnt;    // s_clk pulses still to follow the current one
   logic             burst_q;

   logic tick_c;
   logic accept_c;
   logic timed_c;
   logic load_c;
   logic sample_c;

`ifdef SPI_LOOPBACK_EN
   // mosi holds the current bit through the whole high phase, so the byte
   // comes back unchanged.
   logic unused_miso;
   assign unused_miso = miso;
   assign sample_c    = mosi;
`else
   assign sample_c    = miso;
`endif

   assign accept_c = start && is_ready_state(state);
   assign timed_c  = (state == LEAD) || (state == HIGH) || (state == LOW) ||
                     (state == TRAIL) || (state == GAP);
   assign load_c   = accept_c || (timed_c && tick_c);

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk    (clk),
      .reset  (reset),
      .load   (load_c),
      .tick_c (tick_c)
   );

   // Transfer FSM with registered pin and handshake outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         slave_sel <= 1'b1;
         s_clk     <= 1'b0;
         mosi      <= 1'b0;
         busy      <= 1'b0;
         ready     <= 1'b1;
         done      <= 1'b0;
         rx_data   <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         burst_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, BWAIT: begin
               if (start) begin
                  tx_shift  <= tx_data[SPI_W-2:0];
                  burst_q   <= burst;
                  mosi      <= tx_data[SPI_W-1];
                  slave_sel <= 1'b0;
                  busy      <= 1'b1;
                  ready     <= 1'b0;
                  bit_cnt   <= 3'(SPI_W - 1);
                  state     <= LEAD;
               end
            end
            LEAD: begin
               if (tick_c) begin
                  s_clk    <= 1'b1;
                  rx_shift <= {rx_shift[SPI_W-2:0], sample_c};
                  state    <= HIGH;
               end
            end
            HIGH: begin
               // Falling edge: present the next bit unless this was the last one.
               if (tick_c) begin
                  s_clk <= 1'b0;
                  state <= LOW;
                  if (bit_cnt != 3'd0) begin
                     mosi     <= tx_shift[SPI_W-2];
                     tx_shift <= {tx_shift[SPI_W-3:0], 1'b0};
                  end
               end
            end
            LOW: begin
               if (tick_c) begin
                  if (bit_cnt != 3'd0) begin
                     s_clk    <= 1'b1;
                     rx_shift <= {rx_shift[SPI_W-2:0], sample_c};
                     bit_cnt  <= bit_cnt - 3'd1;
                     state    <= HIGH;
                  end else if (burst_q) begin
                     // Byte complete mid-burst: select stays low.
                     done    <= 1'b1;
                     rx_data <= rx_shift;
                     ready   <= 1'b1;
                     state   <= BWAIT;
                  end else begin
                     state <= TRAIL;
                  end
               end
            end
            TRAIL: begin
               if (tick_c) begin
                  slave_sel <= 1'b1;
                  done      <= 1'b1;
                  rx_data   <= rx_shift;
                  state     <= GAP;
               end
            end
            GAP: begin
               // Minimum deselect time before the next transfer.
               if (tick_c) begin
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 and a CLK_DIV=2 instance share
// one mode-0 slave model (selected by use2) and a pin monitor.
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b0;
   logic       start4 = 1'b0;
   logic       start2 = 1'b0;
   logic       burst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       miso;
   logic       miso_r = 1'b0;
   logic       use2 = 1'b0;
   logic       force0 = 1'b0;

   logic       busy4, ready4, done4, sck4, mosi4, ss4;
   logic [7:0] rx4;
   logic       busy2, ready2, done2, sck2, mosi2, ss2;
   logic [7:0] rx2;

   assign miso = miso_r;

   spi_master #(.CLK_DIV(4), .DATA_W(8)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .burst(burst), .tx_data(tx_data),
      .busy(busy4), .ready(ready4), .done(done4), .rx_data(rx4),
      .s_clk(sck4), .mosi(mosi4), .miso(miso), .slave_sel(ss4)
   );

   spi_master #(.CLK_DIV(2), .DATA_W(8)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .burst(burst), .tx_data(tx_data),
      .busy(busy2), .ready(ready2), .done(done2), .rx_data(rx2),
      .s_clk(sck2), .mosi(mosi2), .miso(miso), .slave_sel(ss2)
   );

   logic       ss_m, sck_m, mosi_m, done_m, busy_m, ready_m;
   logic [7:0] rx_m;
   assign ss_m    = use2 ? ss2    : ss4;
   assign sck_m   = use2 ? sck2   : sck4;
   assign mosi_m  = use2 ? mosi2  : mosi4;
   assign done_m  = use2 ? done2  : done4;
   assign busy_m  = use2 ? busy2  : busy4;
   assign ready_m = use2 ? ready2 : ready4;
   assign rx_m    = use2 ? rx2    : rx4;

   int checks = 0;
   int errors = 0;

   // Slave model and monitor state
   logic [7:0] slv_mem [0:63];
   logic [7:0] rcv_mem [0:63];
   int   slv_ptr = 0;
   int   rcv_cnt = 0;
   logic [7:0] sh_out = 8'h00;
   logic [7:0] sh_in = 8'h00;
   int   bits = 0;
   int   pulses = 0;
   int   low_total = 0, rise_total = 0, done_total = 0, ss_rise = 0, dbl_done = 0;
   int   hi_run = 0, lo_run = 0;
   int   hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
   logic ss_q = 1'b1, sck_q = 1'b0, done_q = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] slv);
`ifdef SPI_LOOPBACK_EN
      return tx;
`else
      return slv;
`endif
   endfunction

   // Mode-0 slave: shift out on s_clk fall, sample mosi on s_clk rise,
   // preload the next byte after every 8th bit; also gathers pin statistics.
   always @(negedge clk) begin
      if (!ss_m) low_total++;
      if (done_m) begin
         done_total++;
         if (done_q) dbl_done++;
      end
      done_q = done_m;
      if (ss_m && !ss_q) ss_rise++;
      if (!ss_m && ss_q) begin
         sh_out = slv_mem[slv_ptr % 64];
         slv_ptr++;
         bits = 0; pulses = 0;
         hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
         hi_run = 0; lo_run = 1;
      end else if (!ss_m) begin
         if (sck_m && !sck_q) begin
            sh_in = {sh_in[6:0], mosi_m};
            bits++; pulses++; rise_total++;
            if (pulses > 1) begin
               if (lo_run < lo_min) lo_min = lo_run;
               if (lo_run > lo_max) lo_max = lo_run;
            end
            hi_run = 1;
         end else if (!sck_m && sck_q) begin
            if (hi_run < hi_min) hi_min = hi_run;
            if (hi_run > hi_max) hi_max = hi_run;
            lo_run = 1;
            if (bits == 8) begin
               rcv_mem[rcv_cnt % 64] = sh_in;
               rcv_cnt++;
               bits = 0;
               sh_out = slv_mem[slv_ptr % 64];
               slv_ptr++;
            end else begin
               sh_out = {sh_out[6:0], 1'b0};
            end
         end else if (sck_m) begin
            hi_run++;
         end else begin
            lo_run++;
         end
      end
      ss_q  = ss_m;
      sck_q = sck_m;
      miso_r = (force0 || ss_m) ? 1'b0 : sh_out[7];
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input logic bst);
      tx_data = b;
      burst   = bst;
      if (use2) start2 = 1'b1;
      else      start4 = 1'b1;
      tick(1);
      start2 = 1'b0;
      start4 = 1'b0;
   endtask

   task automatic wait_done(input string tag, output logic [7:0] rx, output logic ss_at,
                            output logic busy_at, output logic ready_at);
      int n = 0;
      while (!done_m && n < 400) begin
         tick(1);
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_m), 32'd1);
      rx       = rx_m;
      ss_at    = ss_m;
      busy_at  = busy_m;
      ready_at = ready_m;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready_m && n < 400) begin
         tick(1);
         n++;
      end
   endtask

   logic [7:0] rx;
   logic       ss_at, busy_at, ready_at;
   int         gap, low0, rise0, done0, ssr0, rcv0;

   initial begin
      for (int i = 0; i < 64; i++) slv_mem[i] = 8'h00;

      // Reset state
      tick(3);
      check("rst_ss",    32'(ss4),   32'd1);
      check("rst_sck",   32'(sck4),  32'd0);
      check("rst_mosi",  32'(mosi4), 32'd0);
      check("rst_busy",  32'(busy4), 32'd0);
      check("rst_done",  32'(done4), 32'd0);
      check("rst_rx",    32'(rx4),   32'h00);
      check("rst_ready", 32'(ready4), 32'd1);
      check("rst_ss2",   32'(ss2),   32'd1);
      reset = 1'b1;
      tick(2);

      // Single byte A5, slave answers 3C
      slv_mem[slv_ptr % 64] = 8'h3C;
      low0 = low_total; rise0 = rise_total; done0 = done_total; rcv0 = rcv_cnt;
      send(8'hA5, 1'b0);
      wait_done("t2", rx, ss_at, busy_at, ready_at);
      check("t2_rx",       32'(rx), 32'(exp_rx(8'hA5, 8'h3C)));
      check("t2_ss_at_done", 32'(ss_at), 32'd1);
      check("t2_busy_at_done", 32'(busy_at), 32'd1);
      check("t2_ss_low_cycles", 32'(low_total - low0), 32'd72);
      check("t2_sck_pulses", 32'(rise_total - rise0), 32'd8);
      check("t2_hi_min", 32'(hi_min), 32'd4);
      check("t2_hi_max", 32'(hi_max), 32'd4);
      check("t2_lo_min", 32'(lo_min), 32'd4);
      check("t2_lo_max", 32'(lo_max), 32'd4);
      check("t2_slave_cnt", 32'(rcv_cnt - rcv0), 32'd1);
      check("t2_slave_byte", 32'(rcv_mem[(rcv_cnt - 1) % 64]), 32'hA5);
      wait_ready(gap);
      check("t2_gap", 32'(gap), 32'd4);
      check("t2_done_cnt", 32'(done_total - done0), 32'd1);

      // Burst 01, 02, 03; slave answers C1, C2, C3
      slv_mem[slv_ptr % 64]       = 8'hC1;
      slv_mem[(slv_ptr + 1) % 64] = 8'hC2;
      slv_mem[(slv_ptr + 2) % 64] = 8'hC3;
      ssr0 = ss_rise; done0 = done_total; rcv0 = rcv_cnt;
      send(8'h01, 1'b1);
      wait_done("t3a", rx, ss_at, busy_at, ready_at);
      check("t3a_rx", 32'(rx), 32'(exp_rx(8'h01, 8'hC1)));
      check("t3a_ss", 32'(ss_at), 32'd0);
      check("t3a_ready", 32'(ready_at), 32'd1);
      send(8'h02, 1'b1);
      wait_done("t3b", rx, ss_at, busy_at, ready_at);
      check("t3b_rx", 32'(rx), 32'(exp_rx(8'h02, 8'hC2)));
      check("t3b_ss", 32'(ss_at), 32'd0);
      check("t3b_busy", 32'(busy_at), 32'd1);
      send(8'h03, 1'b0);
      wait_done("t3c", rx, ss_at, busy_at, ready_at);
      check("t3c_rx", 32'(rx), 32'(exp_rx(8'h03, 8'hC3)));
      check("t3c_ss", 32'(ss_at), 32'd1);
      wait_ready(gap);
      check("t3_ss_rises", 32'(ss_rise - ssr0), 32'd1);
      check("t3_done_cnt", 32'(done_total - done0), 32'd3);
      check("t3_slave_cnt", 32'(rcv_cnt - rcv0), 32'd3);
      check("t3_slave_b0", 32'(rcv_mem[rcv0 % 64]), 32'h01);
      check("t3_slave_b1", 32'(rcv_mem[(rcv0 + 1) % 64]), 32'h02);
      check("t3_slave_b2", 32'(rcv_mem[(rcv0 + 2) % 64]), 32'h03);

      // Start while busy is ignored
      slv_mem[slv_ptr % 64] = 8'h69;
      done0 = done_total; rcv0 = rcv_cnt;
      send(8'h5A, 1'b0);
      for (int i = 0; i < 100 && !sck_m; i++) tick(1);
      check("t4_sck_seen", 32'(sck_m), 32'd1);
      tx_data = 8'hFF;
      start4  = 1'b1;
      tick(1);
      start4  = 1'b0;
      wait_done("t4", rx, ss_at, busy_at, ready_at);
      check("t4_rx", 32'(rx), 32'(exp_rx(8'h5A, 8'h69)));
      wait_ready(gap);
      tick(80);
      check("t4_done_cnt", 32'(done_total - done0), 32'd1);
      check("t4_slave_cnt", 32'(rcv_cnt - rcv0), 32'd1);
      check("t4_slave_byte", 32'(rcv_mem[rcv0 % 64]), 32'h5A);
      check("t4_idle_busy", 32'(busy_m), 32'd0);

      // Reset in the middle of the first high phase
      slv_mem[slv_ptr % 64] = 8'hFF;
      done0 = done_total;
      send(8'hC3, 1'b0);
      for (int i = 0; i < 100 && !sck_m; i++) tick(1);
      check("t1_sck_seen", 32'(sck_m), 32'd1);
      tick(1);
      reset = 1'b0;
      tick(3);
      check("t1_ss",    32'(ss4),    32'd1);
      check("t1_sck",   32'(sck4),   32'd0);
      check("t1_mosi",  32'(mosi4),  32'd0);
      check("t1_busy",  32'(busy4),  32'd0);
      check("t1_done",  32'(done4),  32'd0);
      check("t1_rx",    32'(rx4),    32'h00);
      check("t1_ready", 32'(ready4), 32'd1);
      check("t1_no_done", 32'(done_total - done0), 32'd0);
      reset = 1'b1;
      tick(2);

      // miso held low: loopback returns tx, pin build returns zero
      force0 = 1'b1;
      slv_mem[slv_ptr % 64] = 8'hFF;
      rcv0 = rcv_cnt;
      send(8'h96, 1'b0);
      wait_done("t5", rx, ss_at, busy_at, ready_at);
      check("t5_rx", 32'(rx), 32'(exp_rx(8'h96, 8'h00)));
      check("t5_slave_byte", 32'(rcv_mem[rcv0 % 64]), 32'h96);
      wait_ready(gap);
      force0 = 1'b0;

      // CLK_DIV=2 instance
      use2 = 1'b1;
      tick(2);
      slv_mem[slv_ptr % 64] = 8'h0F;
      low0 = low_total; rcv0 = rcv_cnt;
      send(8'h80, 1'b0);
      wait_done("t6", rx, ss_at, busy_at, ready_at);
      check("t6_rx", 32'(rx), 32'(exp_rx(8'h80, 8'h0F)));
      check("t6_ss_low_cycles", 32'(low_total - low0), 32'd36);
      check("t6_hi_max", 32'(hi_max), 32'd2);
      check("t6_slave_byte", 32'(rcv_mem[rcv0 % 64]), 32'h80);
      wait_ready(gap);
      check("t6_gap", 32'(gap), 32'd2);

      check("no_double_done", 32'(dbl_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
